// File: rtl/vfd_shiftreg_pkg.sv
// Shared definitions for the vfd_shiftreg_uni block: command opcodes, FSM state type
// and the build-time rotate enable.
// Configuration macro: VFD_SHIFTREG_ROTATE_EN enables the ROTL operation; when it is
// undefined, ROTL completes as a zero-step command.
package vfd_shiftreg_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

`ifdef VFD_SHIFTREG_ROTATE_EN
  localparam bit RotateEn = 1'b1;
`else
  localparam bit RotateEn = 1'b0;
`endif

endpackage

// File: rtl/vfd_shiftreg_uni_if.sv
// Command / result bundle for vfd_shiftreg_uni.
//   slave  : the shift register block (takes commands, drives results)
//   master : the command issuer
// Signals: i_cmd_valid/o_cmd_ready handshake, i_cmd_op, i_cmd_count, i_load_data,
// i_serial_in in; o_result, o_serial_out, o_busy, o_done out.
interface vfd_shiftreg_uni_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_op;
  logic [CNT_W-1:0] i_cmd_count;
  logic [WIDTH-1:0] i_load_data;
  logic             i_serial_in;
  logic [WIDTH-1:0] o_result;
  logic             o_serial_out;
  logic             o_busy;
  logic             o_done;

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_count, i_load_data, i_serial_in,
    output o_cmd_ready, o_result, o_serial_out, o_busy, o_done
  );

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_count, i_load_data, i_serial_in,
    input  o_cmd_ready, o_result, o_serial_out, o_busy, o_done
  );
endinterface

// File: rtl/vfd_shiftreg_core.sv
// Datapath of vfd_shiftreg_uni: the shift register, the single-step mux and the
// serial-out flop.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   load_en_i      parallel load of load_data_i (priority over step_en_i)
//   step_en_i      perform one step of step_op_i this edge
//   serial_in_i    bit inserted by SHL/SHR steps
//   result_o       register contents
//   serial_out_o   bit most recently shifted out
// Configuration macro: VFD_SHIFTREG_ROTATE_EN adds the ROTL step.
module vfd_shiftreg_core
  import vfd_shiftreg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             step_en_i,
  input  op_e              step_op_i,
  input  logic             serial_in_i,
  output logic [WIDTH-1:0] result_o,
  output logic             serial_out_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             ser_q, ser_d;

  always_comb begin
    sr_d  = sr_q;
    ser_d = ser_q;
    if (load_en_i) begin
      sr_d = load_data_i;
    end else if (step_en_i) begin
      unique case (step_op_i)
        OP_SHL: begin
          sr_d  = {sr_q[WIDTH-2:0], serial_in_i};
          ser_d = sr_q[WIDTH-1];
        end
        OP_SHR: begin
          sr_d  = {serial_in_i, sr_q[WIDTH-1:1]};
          ser_d = sr_q[0];
        end
`ifdef VFD_SHIFTREG_ROTATE_EN
        OP_ROTL: begin
          sr_d  = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
          ser_d = sr_q[WIDTH-1];
        end
`else
        OP_ROTL: begin
          // Never stepped: the controller forces a zero count for ROTL.
          sr_d  = sr_q;
          ser_d = ser_q;
        end
`endif
        default: begin
          sr_d  = sr_q;
          ser_d = ser_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= RESET_VALUE;
      ser_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      ser_q <= ser_d;
    end
  end

  assign result_o     = sr_q;
  assign serial_out_o = ser_q;

endmodule

// File: rtl/vfd_shiftreg_uni.sv
// Command-driven shift register: LOAD, SHL, SHR and (optionally) ROTL by a count of
// single-bit steps, one step per clock, with a valid/ready command handshake.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset, priority over every command
//   bus   vfd_shiftreg_uni_if slave modport (command in, result/status out)
// Parameters: WIDTH (2..64), RESET_VALUE (register value after reset).
// Configuration macro: VFD_SHIFTREG_ROTATE_EN enables ROTL; otherwise ROTL is a
// zero-step command that only pulses o_done.
module vfd_shiftreg_uni
  import vfd_shiftreg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  vfd_shiftreg_uni_if.slave   bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             done_q, done_d;

  op_e              cmd_op;
  logic [CNT_W-1:0] n_eff;
  logic             accept;
  logic             load_en, step_en;
  op_e              step_op;
  logic [WIDTH-1:0] result;
  logic             serial_out;

  assign cmd_op = op_e'(bus.i_cmd_op);
  assign accept = bus.i_cmd_valid && (state_q == StIdle);

  // Effective step count: clamp to WIDTH; ROTL without rotate support does nothing.
  always_comb begin
    n_eff = (bus.i_cmd_count > WidthCnt) ? WidthCnt : bus.i_cmd_count;
    if (cmd_op == OP_ROTL && !RotateEn) begin
      n_eff = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    load_en = 1'b0;
    step_en = 1'b0;
    step_op = op_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = cmd_op;
          step_op = cmd_op;
          if (cmd_op == OP_LOAD) begin
            load_en = 1'b1;
            done_d  = 1'b1;
          end else if (n_eff == '0) begin
            done_d = 1'b1;
          end else begin
            // First step happens on the accept edge itself.
            step_en = 1'b1;
            if (n_eff == CntOne) begin
              done_d = 1'b1;
            end else begin
              state_d = StShift;
              cnt_d   = n_eff - CntOne;
            end
          end
        end
      end
      StShift: begin
        // cnt_q counts steps still to do, including this one.
        step_en = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end
        if (cnt_q <= CntOne) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  vfd_shiftreg_core #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .load_en_i   (load_en),
    .load_data_i (bus.i_load_data),
    .step_en_i   (step_en),
    .step_op_i   (step_op),
    .serial_in_i (bus.i_serial_in),
    .result_o    (result),
    .serial_out_o(serial_out)
  );

  assign bus.o_cmd_ready  = (state_q == StIdle);
  assign bus.o_busy       = (state_q == StShift);
  assign bus.o_done       = done_q;
  assign bus.o_result     = result;
  assign bus.o_serial_out = serial_out;

endmodule

// File: tb/tb_vfd_shiftreg_uni.sv
// Self-checking bench for vfd_shiftreg_uni (WIDTH=8). A command-level model builds the
// per-cycle timeline of each accepted command; a negedge process compares every output
// against it. Directed sequences add literal expectations.
module tb_vfd_shiftreg_uni;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef VFD_SHIFTREG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ser;
    logic             busy;
    logic             done;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vfd_shiftreg_uni_if #(.WIDTH(WIDTH)) bus ();
  vfd_shiftreg_uni_if #(.WIDTH(WIDTH)) bus2 ();

  assign bus2.i_cmd_valid = bus.i_cmd_valid;
  assign bus2.i_cmd_op    = bus.i_cmd_op;
  assign bus2.i_cmd_count = bus.i_cmd_count;
  assign bus2.i_load_data = bus.i_load_data;
  assign bus2.i_serial_in = bus.i_serial_in;

  vfd_shiftreg_uni #(.WIDTH(WIDTH), .RESET_VALUE(8'h00)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  vfd_shiftreg_uni #(.WIDTH(WIDTH), .RESET_VALUE(8'h3C)) u_dut_rv (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int n_err = 0;
  int n_chk = 0;

  // Model state
  ent_t             plan[$];
  logic [WIDTH-1:0] m_res;
  logic             m_ser, m_busy, m_done;
  bit               model_valid = 1'b0;
  logic [63:0]      sb;
  int               sidx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-command timeline, one entry per edge from the accept edge onward.
  task automatic build_plan(input logic [1:0] op, input int cnt, input logic [WIDTH-1:0] data);
    int n;
    logic [WIDTH-1:0] r;
    logic so;
    n = (cnt > int'(WIDTH)) ? int'(WIDTH) : cnt;
    if (op == 2'b11 && !ROT) n = 0;
    if (op == 2'b00) begin
      plan.push_back('{res: data, ser: m_ser, busy: 1'b0, done: 1'b1});
    end else if (n == 0) begin
      plan.push_back('{res: m_res, ser: m_ser, busy: 1'b0, done: 1'b1});
    end else begin
      r = m_res;
      for (int k = 0; k < n; k++) begin
        if (op == 2'b01) begin
          so = r[WIDTH-1];
          r  = (r << 1) | WIDTH'(sb[k]);
        end else if (op == 2'b10) begin
          so = r[0];
          r  = (r >> 1) | (WIDTH'(sb[k]) << (WIDTH - 1));
        end else begin
          so = r[WIDTH-1];
          r  = (r << 1) | WIDTH'(so);
        end
        plan.push_back('{res: r, ser: so, busy: (k < n - 1), done: (k == n - 1)});
      end
    end
  endtask

  task automatic model_edge();
    ent_t e;
    if (rst) begin
      plan.delete();
      m_res = '0; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (plan.size() == 0 && bus.i_cmd_valid === 1'b1)
        build_plan(bus.i_cmd_op, int'(bus.i_cmd_count), bus.i_load_data);
      if (plan.size() != 0) begin
        e = plan.pop_front();
        m_res = e.res; m_ser = e.ser; m_busy = e.busy; m_done = e.done;
      end else begin
        m_busy = 1'b0; m_done = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("result", 64'(bus.o_result), 64'(m_res));
      chk("serial_out", 64'(bus.o_serial_out), 64'(m_ser));
      chk("busy", 64'(bus.o_busy), 64'(m_busy));
      chk("done", 64'(bus.o_done), 64'(m_done));
      chk("cmd_ready", 64'(bus.o_cmd_ready), 64'(!m_busy));
    end
  end

  // Issue one command at the next edge, then drop valid.
  task automatic do_cmd(input logic [1:0] op, input int cnt, input logic [WIDTH-1:0] data,
                        input logic [63:0] bits);
    sb = bits;
    sidx = 1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_count = CNT_W'(cnt);
    bus.i_load_data = data;
    bus.i_serial_in = bits[0];
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic step_busy();
    bus.i_serial_in = sb[sidx];
    sidx++;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int nbusy, ndone;
    logic [WIDTH-1:0] exp_r[5];
    logic             exp_d[5];
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = 2'b00;
    bus.i_cmd_count = '0;
    bus.i_load_data = '0;
    bus.i_serial_in = 1'b0;
    sb = '0; sidx = 0;

    // Reset
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst result", 64'(bus.o_result), 64'h00);
    chk("rst result rv3c", 64'(bus2.o_result), 64'h3C);
    chk("rst ready", 64'(bus.o_cmd_ready), 64'd1);
    chk("rst done", 64'(bus.o_done), 64'd0);

    // LOAD 0xA5
    do_cmd(2'b00, 0, 8'hA5, '0);
    chk("load result", 64'(bus.o_result), 64'hA5);
    chk("load done", 64'(bus.o_done), 64'd1);
    chk("load busy", 64'(bus.o_busy), 64'd0);
    tick();
    chk("load done drop", 64'(bus.o_done), 64'd0);

    // SHL 3 from 0x81 with serial 1
    do_cmd(2'b00, 0, 8'h81, '0);
    do_cmd(2'b01, 3, 'x, '1);
    chk("shl s1 result", 64'(bus.o_result), 64'h03);
    chk("shl s1 sout", 64'(bus.o_serial_out), 64'd1);
    chk("shl s1 busy", 64'(bus.o_busy), 64'd1);
    step_busy();
    chk("shl s2 result", 64'(bus.o_result), 64'h07);
    chk("shl s2 sout", 64'(bus.o_serial_out), 64'd0);
    chk("shl s2 busy", 64'(bus.o_busy), 64'd1);
    step_busy();
    chk("shl s3 result", 64'(bus.o_result), 64'h0F);
    chk("shl s3 sout", 64'(bus.o_serial_out), 64'd0);
    chk("shl s3 busy", 64'(bus.o_busy), 64'd0);
    chk("shl s3 done", 64'(bus.o_done), 64'd1);
    tick();

    // SHR count 9 on 0xFF clamps to 8
    do_cmd(2'b00, 0, 8'hFF, '0);
    do_cmd(2'b10, 9, 'x, '0);
    nbusy = 0; ndone = 0;
    if (bus.o_busy) nbusy++;
    if (bus.o_done) ndone++;
    for (int i = 0; i < 20 && bus.o_busy === 1'b1; i++) begin
      step_busy();
      if (bus.o_busy) nbusy++;
      if (bus.o_done) ndone++;
    end
    tick();
    if (bus.o_done) ndone++;
    chk("shr9 result", 64'(bus.o_result), 64'h00);
    chk("shr9 busy cycles", 64'(nbusy), 64'd7);
    chk("shr9 done pulses", 64'(ndone), 64'd1);

    // Reset in the middle of SHL 5
    do_cmd(2'b00, 0, 8'h01, '0);
    do_cmd(2'b01, 5, 'x, '0);
    step_busy();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort result", 64'(bus.o_result), 64'h00);
    chk("abort result rv3c", 64'(bus2.o_result), 64'h3C);
    chk("abort ready", 64'(bus.o_cmd_ready), 64'd1);
    chk("abort done", 64'(bus.o_done), 64'd0);
    tick();
    chk("abort done later", 64'(bus.o_done), 64'd0);

    // ROTL 4 on 0x12
    do_cmd(2'b00, 0, 8'h12, '0);
    do_cmd(2'b11, 4, 'x, '0);
    if (!ROT) chk("rotl nop done", 64'(bus.o_done), 64'd1);
    for (int i = 0; i < 20 && bus.o_busy === 1'b1; i++) step_busy();
    chk("rotl result", 64'(bus.o_result), ROT ? 64'h21 : 64'h12);
    tick();

    // Queue with valid held high: LOAD 0x11, SHR 3, LOAD 0x22
    exp_r = '{8'h11, 8'h08, 8'h04, 8'h02, 8'h22};
    exp_d = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    sb = '0; sidx = 0;
    bus.i_serial_in = 1'b0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op = 2'b00; bus.i_load_data = 8'h11; bus.i_cmd_count = '0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin bus.i_cmd_op = 2'b10; bus.i_cmd_count = CNT_W'(3); end
      if (i == 1) begin bus.i_cmd_op = 2'b00; bus.i_load_data = 8'h22; end
      chk($sformatf("queue result %0d", i), 64'(bus.o_result), 64'(exp_r[i]));
      chk($sformatf("queue done %0d", i), 64'(bus.o_done), 64'(exp_d[i]));
      if (bus.o_done) ndone++;
    end
    bus.i_cmd_valid = 1'b0;
    tick();
    if (bus.o_done) ndone++;
    chk("queue done pulses", 64'(ndone), 64'd3);
    chk("queue final result", 64'(bus.o_result), 64'h22);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!m_busy) begin
        sb = {$urandom, $urandom};
        sidx = 1;
        bus.i_cmd_valid = ($urandom_range(0, 3) != 0);
        bus.i_cmd_op    = 2'($urandom);
        bus.i_cmd_count = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
        bus.i_load_data = WIDTH'($urandom);
        bus.i_serial_in = sb[0];
      end else begin
        bus.i_cmd_valid = 1'($urandom);
        bus.i_cmd_op    = 2'($urandom);
        bus.i_cmd_count = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
        bus.i_load_data = WIDTH'($urandom);
        bus.i_serial_in = sb[sidx];
        sidx++;
      end
      tick();
    end
    rst = 1'b0;
    bus.i_cmd_valid = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
